// File: rtl/tick_sched_pkg.sv
// Shared defaults, ms divider helper and per-channel state encoding for tick_scheduler.
package tick_sched_pkg;

  localparam int DEF_CLK_HZ   = 100_000_000;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_PERIOD_W = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // Clock cycles per millisecond; CLK_HZ is expected to be a multiple of 1000.
  function automatic int calc_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Control/status bundle between a host block and tick_scheduler (master drives enables/periods).
interface tick_scheduler_if import tick_sched_pkg::*; #(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PERIOD_W = DEF_PERIOD_W
);

  logic [NUM_CH-1:0]          i_enable;
  logic [NUM_CH*PERIOD_W-1:0] i_period;
  logic                       i_overrun_clr;
  logic                       o_ms_tick;
  logic [NUM_CH-1:0]          o_event;
  logic [NUM_CH-1:0]          o_overrun;

  modport master (
    output i_enable, i_period, i_overrun_clr,
    input  o_ms_tick, o_event, o_overrun
  );

  modport slave (
    input  i_enable, i_period, i_overrun_clr,
    output o_ms_tick, o_event, o_overrun
  );

endinterface

// File: rtl/ms_prescaler.sv
// Free-running 0..DIV-1 counter; o_ms_tick is high for the one cycle the count sits at DIV-1.
// Latency: first strobe DIV cycles out of reset, then every DIV cycles; no backpressure.
module ms_prescaler import tick_sched_pkg::*; #(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  output logic o_ms_tick
);

  localparam int DIV   = calc_div(CLK_HZ);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign o_ms_tick = (cnt == LAST);

endmodule

// File: rtl/tick_scheduler.sv
// Periodic per-channel ms event generator with round-robin one-event-per-cycle issue; event 2 cycles
// after the expiring tick when uncontended, no backpressure. Overrun flags need TICK_SCHED_OVERRUN_EN.
module tick_scheduler import tick_sched_pkg::*; #(
  parameter int CLK_HZ   = DEF_CLK_HZ,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input logic              clk_100MHz,
  input logic              rst_n,
  tick_scheduler_if.slave  sched
);

  localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic ms_tick;

  ms_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .o_ms_tick  (ms_tick)
  );

  ch_state_t           state_q [NUM_CH];
  ch_state_t           state_d [NUM_CH];
  logic [PERIOD_W-1:0] count_q [NUM_CH];
  logic [PERIOD_W-1:0] count_d [NUM_CH];
  logic [PERIOD_W-1:0] period  [NUM_CH];
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [NUM_CH-1:0]   event_q;
  logic [NUM_CH-1:0]   ovr_q, ovr_d;
  logic [NUM_CH-1:0]   run_ok, expire, eligible, grant;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic [RR_W-1:0]     gidx;
  logic                found;

  always_comb begin
    period = '{default: '0};
    run_ok = '0;
    expire = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      period[k] = sched.i_period[k*PERIOD_W +: PERIOD_W];
      run_ok[k] = sched.i_enable[k] && (period[k] != '0);
      expire[k] = (state_q[k] == RUN) && run_ok[k] && ms_tick && (count_q[k] == PERIOD_W'(1));
    end
  end

  // A channel being disabled this cycle must not win, so it can never emit afterwards.
  assign eligible = pending_q & run_ok;

  // Cyclic search from rr: first pass covers rr..NUM_CH-1, second pass wraps to 0..rr-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    rr_d  = rr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && eligible[k] && (RR_W'(k) >= rr_q)) begin
        found    = 1'b1;
        gidx     = RR_W'(k);
        grant[k] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && eligible[k]) begin
        found    = 1'b1;
        gidx     = RR_W'(k);
        grant[k] = 1'b1;
      end
    end
    if (found) begin
      rr_d = (gidx == RR_W'(NUM_CH - 1)) ? '0 : gidx + RR_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = pending_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (state_q[k] == IDLE) begin
        if (run_ok[k]) begin
          state_d[k] = RUN;
          count_d[k] = period[k];
        end
      end else if (!run_ok[k]) begin
        state_d[k]   = IDLE;
        count_d[k]   = '0;
        pending_d[k] = 1'b0;
      end else begin
        // Re-expiry while being granted keeps pending set; otherwise the two events merge.
        pending_d[k] = (pending_q[k] & ~grant[k]) | expire[k];
        if (ms_tick) begin
          count_d[k] = expire[k] ? period[k] : count_q[k] - PERIOD_W'(1);
        end
      end
    end
  end

`ifdef TICK_SCHED_OVERRUN_EN
  always_comb begin
    ovr_d = (sched.i_overrun_clr ? '0 : ovr_q) | (expire & pending_q & ~grant);
  end
`else
  logic unused_clr;
  assign unused_clr = sched.i_overrun_clr;

  always_comb begin
    ovr_d = '0;
  end
`endif

  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= IDLE;
        count_q[k] <= '0;
      end
      pending_q <= '0;
      event_q   <= '0;
      ovr_q     <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      event_q   <= grant;
      ovr_q     <= ovr_d;
      rr_q      <= rr_d;
    end
  end

  assign sched.o_ms_tick = ms_tick;
  assign sched.o_event   = event_q;
  assign sched.o_overrun = ovr_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: expected ticks/events are queued by the stimulus and consumed by a monitor.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int NCH = 4;
  localparam int PW  = 10;

`ifdef TICK_SCHED_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  typedef struct {
    int             cyc;
    logic [NCH-1:0] vec;
  } exp_ev_t;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  exp_ev_t ev_q[$];
  int      tick_q[$];

  always #5 clk = ~clk;

  tick_scheduler_if #(.NUM_CH(NCH), .PERIOD_W(PW)) ifa ();
  tick_scheduler_if #(.NUM_CH(NCH), .PERIOD_W(PW)) ifb ();

  tick_scheduler #(.CLK_HZ(10_000), .NUM_CH(NCH), .PERIOD_W(PW)) dut_a (
    .clk_100MHz (clk),
    .rst_n      (rst_a_n),
    .sched      (ifa.slave)
  );

  tick_scheduler #(.CLK_HZ(2_000), .NUM_CH(NCH), .PERIOD_W(PW)) dut_b (
    .clk_100MHz (clk),
    .rst_n      (rst_b_n),
    .sched      (ifb.slave)
  );

  // Cycle n is the n-th cycle with rst_a_n high; it ends at the n-th rising edge after reset.
  always @(posedge clk) cyc <= rst_a_n ? cyc + 1 : 0;

  function automatic int cur();
    return cyc + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cur());
    end
  endtask

  task automatic push_ev(input int c, input logic [NCH-1:0] v);
    exp_ev_t e;
    e.cyc = c;
    e.vec = v;
    ev_q.push_back(e);
  endtask

  task automatic arm_ticks();
    tick_q.delete();
    for (int n = 1; n <= 40; n++) tick_q.push_back(10 * n);
  endtask

  task automatic wait_cyc(input int n);
    for (int g = 0; g < 300 && cur() < n; g++) @(negedge clk);
    if (cur() != n) begin
      total++;
      bad++;
      $display("FAIL wait_cyc: reached cycle %0d, wanted %0d", cur(), n);
    end
  endtask

  always @(negedge clk) begin
    exp_ev_t e;
    int      t;
    if (ifa.o_ms_tick) begin
      if (tick_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tick_spurious: tick at cycle %0d, none expected", cur());
      end else begin
        t = tick_q.pop_front();
        chk("tick_cycle", cur(), t);
      end
    end
    if (ifa.o_event != '0) begin
      if (ev_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL event_spurious: o_event=%b at cycle %0d, none expected", ifa.o_event, cur());
      end else begin
        e = ev_q.pop_front();
        chk("event_cycle", cur(), e.cyc);
        chk("event_vec", ifa.o_event, e.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cur());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ifa.i_enable = '0; ifa.i_period = '0; ifa.i_overrun_clr = 1'b0;
    ifb.i_enable = '0; ifb.i_period = '0; ifb.i_overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tick", ifa.o_ms_tick, 0);
    chk("rst_event", ifa.o_event, 0);
    chk("rst_overrun", ifa.o_overrun, 0);

    // ch0 period 3: expiries on ticks 30, 60, 90
    ifa.i_enable = 4'b0001;
    ifa.i_period = {10'd0, 10'd0, 10'd0, 10'd3};
    arm_ticks();
    push_ev(32, 4'b0001);
    push_ev(62, 4'b0001);
    push_ev(92, 4'b0001);
    rst_a_n = 1'b1;
    wait_cyc(5);
    chk("early_event", ifa.o_event, 0);
    chk("early_tick", ifa.o_ms_tick, 0);
    wait_cyc(95);
    ifa.i_enable = 4'b0000;

    // all channels pending after tick 100, then reset before any is issued
    wait_cyc(96);
    ifa.i_enable = 4'b1111;
    ifa.i_period = {4{10'd1}};
    wait_cyc(101);
    rst_a_n = 1'b0;
    arm_ticks();
    @(negedge clk);
    chk("midrst_event", ifa.o_event, 0);
    chk("midrst_tick", ifa.o_ms_tick, 0);
    chk("midrst_overrun", ifa.o_overrun, 0);
    rst_a_n = 1'b1;

    // period 1 on all four: ch0..ch3 in consecutive cycles after each tick
    for (int t = 10; t <= 30; t += 10) begin
      push_ev(t + 2, 4'b0001);
      push_ev(t + 3, 4'b0010);
      push_ev(t + 4, 4'b0100);
      push_ev(t + 5, 4'b1000);
    end
    wait_cyc(36);
    chk("no_overrun_a", ifa.o_overrun, 0);
    ifa.i_enable = 4'b0011;

    // ch1 loses to ch0 at tick 40 and is disabled while still pending
    push_ev(42, 4'b0001);
    wait_cyc(41);
    ifa.i_enable = 4'b0001;

    // ch0 period 1 -> 2 after reload at tick 50: expiries at 60 and 80
    push_ev(52, 4'b0001);
    push_ev(62, 4'b0001);
    push_ev(82, 4'b0001);
    wait_cyc(53);
    ifa.i_period[9:0] = 10'd2;
    wait_cyc(85);
    ifa.i_enable = 4'b0000;
    wait_cyc(90);
    chk("event_queue_left", ev_q.size(), 0);

    // DIV=2, three period-1 channels: ch2 loses arbitration on its second expiry
    ifb.i_enable = 4'b0111;
    ifb.i_period = {10'd0, 10'd1, 10'd1, 10'd1};
    rst_b_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("overrun_ch2", ifb.o_overrun[2], OVR_EXP);
    ifb.i_enable = 4'b0000;
    repeat (4) @(negedge clk);
    chk("overrun_ch2_sticky", ifb.o_overrun[2], OVR_EXP);
    ifb.i_overrun_clr = 1'b1;
    @(negedge clk);
    ifb.i_overrun_clr = 1'b0;
    chk("overrun_cleared", ifb.o_overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
